uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud): clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_data valid.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte.
REQ-008 SHALL have port txd  output  1  serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-010 SHALL accept a byte on every rising edge with tx_valid=1 and tx_ready=1; no other edge accepts a byte.
REQ-011 SHALL drive tx_ready = FIFO not full, decoded from registered count only; it SHALL not depend combinationally on tx_valid.
REQ-012 SHALL tolerate tx_valid asserted with tx_ready=0: byte is not stored and is not lost from FIFO state; upstream holds or drops it.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: txd=1; if FIFO non-empty, pop the head into a shift register, clear the bit counter, enter START on the same edge.
REQ-015 Latency: a byte accepted into an empty FIFO at edge E with the FSM in IDLE SHALL drive txd=0 from edge E+1.
REQ-016 START: txd=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles; 3-bit index 0..7; after bit 7, STOP.
REQ-018 STOP: txd=1 for exactly CLKS_PER_BIT cycles; at the end, if FIFO non-empty, pop and enter START on the same edge (no idle gap); else IDLE.
REQ-019 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have zero extra cycles between them.
REQ-020 Baud counter SHALL be $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1 and wrapping to 0 at each bit boundary.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; pop from full and push in the same cycle SHALL not occur (tx_ready=0).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH (width $clog2(FIFO_DEPTH)+1).
REQ-023 busy SHALL equal (state != IDLE) or (count != 0).

Reset
REQ-024 While rst_n=0: state=IDLE, txd=1, busy=0, count=0, pointers=0, tx_ready=1; no byte is accepted.
REQ-025 Reset mid-frame SHALL force txd=1 immediately (asynchronously) and discard the frame in progress and all queued bytes.
REQ-026 The first byte SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 Package uart_pkg SHALL hold the tx state enum typedef and the default CLKS_PER_BIT constant, shared with the future uart_rx.
REQ-028 FIFO SHALL be a sub-module byte_fifo (params DEPTH, WIDTH=8; ports push, pop, din, dout, full, empty, count); uart_tx holds FSM, baud counter, shift register.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte 0x61 at edge E -> txd low from E+1; bit sequence 0,1,0,0,0,0,1,1,0,1, each 4 cycles; IDLE and busy=0 at E+41.
REQ-030 Six bytes 0x61..0x66 offered on consecutive cycles -> first five accepted on consecutive edges, tx_ready=0 after the fifth until the second pop; all six frames contiguous, exactly 40 cycles apart, in order.
REQ-031 FIFO full, tx_valid=1, data 0x55 -> not accepted while tx_ready=0; accepted on the first edge with tx_ready=1; transmitted last, uncorrupted.
REQ-032 rst_n pulsed low during DATA bit 3 of 0x64 with two bytes queued -> txd=1 immediately; no further frames; busy=0; next byte 0x41 transmits normally.
REQ-033 Bytes 0x00 then 0xFF -> frame bits 0,0x8,1 then 0,1x8,1; stop/start boundary exactly at 40-cycle spacing.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default bit timing.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with registered occupancy count; dout shows the head entry.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back-to-back with no idle gap.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for a queued byte
//   TX_START | start bit (low) for one bit period
//   TX_DATA  | 8 data bits, LSB first, one bit period each
//   TX_STOP  | stop bit (high); chains straight into the next frame if one is queued
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;

    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          bit_end;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid && tx_ready),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state_q != TX_IDLE) || (fifo_count != '0);
    assign txd      = txd_q;
    assign bit_end  = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_dout;
                    bit_idx_d = '0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    state_d = TX_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) state_d = TX_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_dout;
                        bit_idx_d = '0;
                        state_d   = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = TX_IDLE;
        endcase

        // Line level follows the state being entered so the start bit appears on the pop edge.
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit, 4-entry FIFO; txd is logged every cycle.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       txd;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic txd_log [4096];

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] pd [8];
    logic [9:0] bf [6];
    int         acc [8];

    uart_tx #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 4096) txd_log[cyc] <= txd;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Frame bit i is expected on four consecutive logged cycles starting at s + 4*i.
    task automatic check_frame(input int s, input logic [9:0] frame, input string name);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] got;
            for (int k = 0; k < 4; k++) got[k] = txd_log[s + 4*i + k];
            chk($sformatf("%s_bit%0d", name, i), {28'd0, got}, {28'd0, {4{frame[i]}}});
        end
    endtask

    task automatic check_after(input int e, input logic [9:0] frame, input string name);
        wait_to(e);
        chk({name, "_busy_accept"}, busy, 1'b1);
        wait_to(e + 40);
        chk({name, "_busy_last"}, busy, 1'b1);
        wait_to(e + 41);
        chk({name, "_busy_done"}, busy, 1'b0);
        chk({name, "_txd_idle"}, txd, 1'b1);
        chk({name, "_txd_before"}, txd_log[e], 1'b1);
        check_frame(e + 1, frame, name);
    endtask

    task automatic send_one(input logic [7:0] data, input logic [9:0] frame, input string name);
        int e;
        @(negedge clk);
        chk({name, "_ready"}, tx_ready, 1'b1);
        tx_data  = data;
        tx_valid = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_after(e, frame, name);
    endtask

    task automatic push_seq(input int n);
        int guard;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            tx_data  = pd[i];
            tx_valid = 1'b1;
            guard = 0;
            while (!tx_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) chk($sformatf("push%0d_timeout", i), 32'(guard), 32'd0);
            acc[i] = cyc + 1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic burst(input string name);
        int e0;
        push_seq(6);
        e0 = acc[0];
        for (int i = 1; i < 5; i++)
            chk($sformatf("%s_acc%0d", name, i), 32'(acc[i]), 32'(e0 + i));
        chk({name, "_acc5"}, 32'(acc[5]), 32'(e0 + 42));
        wait_to(e0 + 240);
        chk({name, "_busy_last"}, busy, 1'b1);
        wait_to(e0 + 241);
        chk({name, "_busy_done"}, busy, 1'b0);
        for (int i = 0; i < 6; i++)
            check_frame(e0 + 1 + 40*i, bf[i], $sformatf("%s_f%0d", name, i));
    endtask

    initial begin
        int e0;
        int r;
        int lows;

        vecs[0] = '{data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{data: 8'h80, frame: 10'h300};
        vecs[2] = '{data: 8'h01, frame: 10'h202};
        vecs[3] = '{data: 8'h61, frame: 10'h2C2};

        // Byte offered throughout reset must only be taken on the first edge after release.
        tx_data  = 8'h61;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        rst_n = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_after(e0, 10'h2C2, "first_61");

        for (int v = 0; v < 4; v++)
            send_one(vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));

        pd[0] = 8'h61; pd[1] = 8'h62; pd[2] = 8'h63; pd[3] = 8'h64; pd[4] = 8'h65; pd[5] = 8'h66;
        bf[0] = 10'h2C2; bf[1] = 10'h2C4; bf[2] = 10'h2C6; bf[3] = 10'h2C8; bf[4] = 10'h2CA; bf[5] = 10'h2CC;
        burst("six");

        pd[0] = 8'h31; pd[1] = 8'h32; pd[2] = 8'h33; pd[3] = 8'h34; pd[4] = 8'h35; pd[5] = 8'h55;
        bf[0] = 10'h262; bf[1] = 10'h264; bf[2] = 10'h266; bf[3] = 10'h268; bf[4] = 10'h26A; bf[5] = 10'h2AA;
        burst("full55");

        pd[0] = 8'h00; pd[1] = 8'hFF;
        push_seq(2);
        e0 = acc[0];
        chk("zf_acc1", 32'(acc[1]), 32'(e0 + 1));
        wait_to(e0 + 81);
        chk("zf_busy_done", busy, 1'b0);
        chk("zf_stop_edge", txd_log[e0 + 40], 1'b1);
        chk("zf_start_edge", txd_log[e0 + 41], 1'b0);
        check_frame(e0 + 1, 10'h200, "zf_00");
        check_frame(e0 + 41, 10'h3FE, "zf_ff");

        // Reset pulse during data bit 3 of 0x64 with two more bytes queued.
        pd[0] = 8'h64; pd[1] = 8'h65; pd[2] = 8'h66;
        push_seq(3);
        e0 = acc[0];
        wait_to(e0 + 1 + 17);
        chk("mid_txd_bit3", txd, 1'b0);
        chk("mid_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", txd, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", tx_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        wait_to(r + 60);
        lows = 0;
        for (int i = r + 1; i < r + 60; i++) if (txd_log[i] !== 1'b1) lows++;
        chk("mid_no_frames", 32'(lows), 32'd0);
        chk("mid_busy_after", busy, 1'b0);
        send_one(8'h41, 10'h282, "post_rst_41");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
